// File: rtl/snd_i2s_tx.sv
// I2S transmitter for the cartridge sound bus: one-deep sample buffer, per-frame gain ramp,
// and 256fs/64fs/32-bit-slot serialization. All bit timing comes from the incoming frame phase.
module snd_i2s_tx #(
   parameter int RAMP_STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snd_on,
   input  logic        next_sample,
   input  logic [8:0]  phase,
   input  logic [15:0] snd_l,
   input  logic [15:0] snd_r,
   input  logic        flag_clr,
   output logic        i2s_mck,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_sdat,
   output logic        underrun,
   output logic        overrun,
   output logic [8:0]  gain
);

   logic [8:0]  r_ph_q;
   logic [15:0] r_pend_l, r_pend_r, r_raw_l, r_raw_r, r_fl, r_fr;
   logic        r_pend_vld;
   logic [8:0]  r_gain;
   logic        r_mck, r_bck, r_lrck, r_sdat, r_underrun, r_overrun;

   logic        w_fs;
   logic [15:0] w_sel_l, w_sel_r, w_word;
   logic [9:0]  w_gup;
   logic [8:0]  w_gnx;
   logic signed [24:0] w_gx, w_sl_x, w_sr_x, w_prod_l, w_prod_r;
   logic [4:0]  w_j, w_idx;
   logic        w_bit;
   logic [17:0] w_unused_bits;

   assign w_fs = (phase == 9'd0) && (r_ph_q != 9'd0);

   // Live inputs win at fs so a driver issuing next_sample on the frame edge is not a frame late.
   always_comb begin
      w_sel_l = r_raw_l;
      w_sel_r = r_raw_r;
      if (next_sample) begin
         w_sel_l = snd_l;
         w_sel_r = snd_r;
      end else if (r_pend_vld) begin
         w_sel_l = r_pend_l;
         w_sel_r = r_pend_r;
      end
   end

   assign w_gup = {1'b0, r_gain} + 10'(RAMP_STEP);
   always_comb begin
      w_gnx = r_gain;
      if (snd_on)
         w_gnx = (w_gup > 10'd256) ? 9'd256 : w_gup[8:0];
      else
         w_gnx = (r_gain < 9'(RAMP_STEP)) ? 9'd0 : r_gain - 9'(RAMP_STEP);
   end

   // Gain is at most 256, so a 25-bit signed product holds the full result.
   assign w_gx     = {16'd0, w_gnx};
   assign w_sl_x   = {{9{w_sel_l[15]}}, w_sel_l};
   assign w_sr_x   = {{9{w_sel_r[15]}}, w_sel_r};
   assign w_prod_l = w_sl_x * w_gx;
   assign w_prod_r = w_sr_x * w_gx;

   assign w_j    = phase[7:3];
   assign w_idx  = 5'd16 - w_j;
   assign w_word = phase[8] ? r_fr : r_fl;
   assign w_bit  = (w_j >= 5'd1 && w_j <= 5'd16) ? w_word[w_idx[3:0]] : 1'b0;

   assign w_unused_bits = {w_prod_l[24], w_prod_l[7:0], w_prod_r[24], w_prod_r[7:0], w_idx[4]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph_q     <= '0;
         r_pend_l   <= '0;
         r_pend_r   <= '0;
         r_pend_vld <= 1'b0;
         r_raw_l    <= '0;
         r_raw_r    <= '0;
         r_fl       <= '0;
         r_fr       <= '0;
         r_gain     <= '0;
         r_mck      <= 1'b0;
         r_bck      <= 1'b0;
         r_lrck     <= 1'b0;
         r_sdat     <= 1'b0;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_ph_q <= phase;
         r_mck  <= phase[0];
         r_bck  <= phase[2];
         r_lrck <= phase[8];
         r_sdat <= w_bit;
         if (next_sample) begin
            r_pend_l <= snd_l;
            r_pend_r <= snd_r;
         end
         if (w_fs) begin
            r_pend_vld <= 1'b0;
            r_gain     <= w_gnx;
            r_raw_l    <= w_sel_l;
            r_raw_r    <= w_sel_r;
            r_fl       <= w_prod_l[23:8];
            r_fr       <= w_prod_r[23:8];
         end else if (next_sample) begin
            r_pend_vld <= 1'b1;
         end
         if (w_fs && !next_sample && !r_pend_vld) r_underrun <= 1'b1;
         else if (flag_clr)                       r_underrun <= 1'b0;
         if (next_sample && r_pend_vld && !w_fs)  r_overrun <= 1'b1;
         else if (flag_clr)                       r_overrun <= 1'b0;
      end
   end

   assign i2s_mck  = r_mck;
   assign i2s_bck  = r_bck;
   assign i2s_lrck = r_lrck;
   assign i2s_sdat = r_sdat;
   assign underrun = r_underrun;
   assign overrun  = r_overrun;
   assign gain     = r_gain;

endmodule

// File: tb/tb_snd_i2s_tx.sv
// Bench for snd_i2s_tx: drives frames of phase, decodes the I2S pins and compares each frame
// against a queue of expected pairs pushed when the frame load is stimulated.
module tb_snd_i2s_tx;

   logic        clk = 1'b0;
   logic        rst, snd_on, next_sample, flag_clr;
   logic [8:0]  phase;
   logic [15:0] snd_l, snd_r;
   logic        i2s_mck, i2s_bck, i2s_lrck, i2s_sdat, underrun, overrun;
   logic [8:0]  gain;

   snd_i2s_tx #(.RAMP_STEP(4)) dut (
      .clk(clk), .rst(rst), .snd_on(snd_on), .next_sample(next_sample), .phase(phase),
      .snd_l(snd_l), .snd_r(snd_r), .flag_clr(flag_clr),
      .i2s_mck(i2s_mck), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_sdat(i2s_sdat),
      .underrun(underrun), .overrun(overrun), .gain(gain)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
   typedef struct { logic [15:0] s; logic [15:0] exp; } vec_t;

   int    checks = 0, errors = 0;
   pair_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] scale(input logic [15:0] s, input int g);
      int          p;
      logic [31:0] t;
      p = int'($signed(s)) * g;
      t = 32'(p >>> 8);
      return t[15:0];
   endfunction

   // model state
   int    eg, ph_div;
   logic  m_pv, eu, eo;
   pair_t m_pend, m_raw;
   bit    first;
   // per-frame stimulus
   logic  f_on, f_byp, f_clr, f_rst200, f_lr_chk;
   int    f_n;
   pair_t f_b, f_s1, f_s2;

   // I2S decoder
   logic        d_bck_q = 1'b0, d_lr_q = 1'b0;
   logic [31:0] d_sh = '0, d_left = '0;
   int          d_cnt = 0, nfr = 0;
   pair_t       dec;

   always @(negedge clk) begin
      if (rst) begin
         d_bck_q = 1'b0; d_lr_q = 1'b0; d_sh = '0; d_left = '0; d_cnt = 0;
      end else begin
         if (i2s_lrck != d_lr_q) d_cnt = 0;
         d_lr_q = i2s_lrck;
         if (i2s_bck && !d_bck_q) begin
            d_sh = {d_sh[30:0], i2s_sdat};
            d_cnt++;
            if (d_cnt == 32) begin
               d_cnt = 0;
               if (!i2s_lrck) d_left = d_sh;
               else if (sbq.size() == 0) chk("sb_empty", 32'(sbq.size()), 1);
               else begin
                  pair_t e;
                  e = sbq.pop_front();
                  chk("frame_l", {16'd0, d_left[30:15]}, {16'd0, e.l});
                  chk("frame_r", {16'd0, d_sh[30:15]}, {16'd0, e.r});
                  chk("slot_pad", {d_left[31], d_left[14:0], d_sh[31], d_sh[14:0]}, 0);
                  dec.l = d_left[30:15];
                  dec.r = d_sh[30:15];
                  nfr++;
               end
            end
         end
         d_bck_q = i2s_bck;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      eg = 0; m_pv = 0; eu = 0; eo = 0; m_pend = '{0, 0}; m_raw = '{0, 0};
      sbq.delete();
      sbq.push_back('{16'h0, 16'h0});
      first = 1;
   endtask

   task automatic run_frame();
      pair_t      sel, s;
      logic [8:0] p9;
      for (int p = 0; p < 512; p++) begin
         p9 = 9'(p);
         phase = p9;
         if (p == 0 && !first) begin
            snd_on = f_on;
            if (f_byp) begin
               next_sample = 1; snd_l = f_b.l; snd_r = f_b.r;
            end
            eg = f_on ? ((eg + 4 > 256) ? 256 : eg + 4) : ((eg < 4) ? 0 : eg - 4);
            if (f_byp) sel = f_b;
            else if (m_pv) sel = m_pend;
            else begin sel = m_raw; eu = 1; end
            m_raw = sel; m_pv = 0;
            sbq.push_back('{scale(sel.l, eg), scale(sel.r, eg)});
         end
         if ((p == 100 && f_n >= 1) || (p == 300 && f_n >= 2)) begin
            s = (p == 100) ? f_s1 : f_s2;
            next_sample = 1; snd_l = s.l; snd_r = s.r;
            if (m_pv) eo = 1;
            m_pend = s; m_pv = 1;
         end
         if (p == 50 && f_clr) begin
            flag_clr = 1; eu = 0; eo = 0;
         end
         if (f_lr_chk && p == 256) chk("lrck_before_edge", {31'd0, i2s_lrck}, 0);
         tick();
         next_sample = 0; flag_clr = 0;
         if (f_lr_chk && (p == 255 || p == 256 || p == 301))
            chk("pins_latency", {29'd0, i2s_lrck, i2s_bck, i2s_mck}, {29'd0, p9[8], p9[2], p9[0]});
         if (p == 10) begin
            chk("gain", {23'd0, gain}, 32'(eg));
            chk("underrun", {31'd0, underrun}, {31'd0, eu});
            chk("overrun", {31'd0, overrun}, {31'd0, eo});
         end
         if (f_rst200 && p == 200) begin
            rst = 1;
            #1;
            chk("rst_async_pins", {26'd0, i2s_mck, i2s_bck, i2s_lrck, i2s_sdat, underrun, overrun}, 0);
            chk("rst_async_gain", {23'd0, gain}, 0);
            return;
         end
         repeat (ph_div - 1) tick();
      end
      first = 0;
   endtask

   vec_t  tbl[4];
   pair_t fill;
   int    n0;

   initial begin
      tbl[0] = '{16'h4000, 16'h2000};
      tbl[1] = '{16'h8000, 16'hC000};
      tbl[2] = '{16'hFFFF, 16'hFFFF};
      tbl[3] = '{16'h7FFF, 16'h3FFF};
      fill   = '{16'h1234, 16'hEDCB};

      rst = 1; snd_on = 0; next_sample = 0; flag_clr = 0; phase = 0; snd_l = 0; snd_r = 0;
      f_on = 1; f_byp = 0; f_clr = 0; f_rst200 = 0; f_lr_chk = 0; f_n = 1;
      f_b = '{0, 0}; f_s1 = fill; f_s2 = '{0, 0};
      ph_div = 2;
      model_reset();
      repeat (3) tick();
      chk("reset_pins", {26'd0, i2s_mck, i2s_bck, i2s_lrck, i2s_sdat, underrun, overrun}, 0);
      chk("reset_gain", {23'd0, gain}, 0);
      rst = 0;
      phase = 9'd0;
      repeat (4) tick();
      chk("hold_no_change", {23'd0, gain} | {26'd0, i2s_mck, i2s_bck, i2s_lrck, i2s_sdat, underrun, overrun}, 0);

      // ramp to 124, then the last of these frames sends the first scaling vector
      for (int i = 0; i < 32; i++) begin
         if (i == 4) ph_div = 1;
         if (i == 31) f_s1 = '{tbl[0].s, tbl[0].s};
         run_frame();
      end

      // each vector rides a frame at gain 128; the filler frame drops back to 124
      for (int i = 0; i < 4; i++) begin
         f_on = 1; f_s1 = fill;
         run_frame();
         chk("scale_gain", {23'd0, gain}, 128);
         chk("scale_tbl", {16'd0, dec.l}, {16'd0, tbl[i].exp});
         f_on = 0;
         f_s1 = (i < 3) ? '{tbl[i+1].s, tbl[i+1].s} : fill;
         run_frame();
      end

      f_on = 1; f_s1 = fill;
      while (eg < 256) run_frame();
      run_frame();
      chk("integrity_l", {16'd0, dec.l}, 32'h1234);
      chk("integrity_r", {16'd0, dec.r}, 32'hEDCB);

      // underrun: skip one sample, expect a repeat and a sticky flag until cleared
      f_n = 0; run_frame();
      f_n = 1; f_s1 = '{16'h5555, 16'hAAAA}; run_frame();
      chk("underrun_repeat", {16'd0, dec.l}, 32'h1234);
      chk("underrun_set", {31'd0, underrun}, 1);
      f_clr = 1; f_s1 = fill; run_frame();
      f_clr = 0;
      chk("underrun_clr", {31'd0, underrun}, 0);

      // overrun: two samples in one frame, newer one wins
      f_n = 2; f_s1 = '{16'h1111, 16'h1111}; f_s2 = '{16'h2222, 16'h2222}; run_frame();
      f_n = 1; f_s1 = fill; run_frame();
      chk("overrun_data", {16'd0, dec.l}, 32'h2222);
      chk("overrun_set", {31'd0, overrun}, 1);

      // bypass: sample coincident with fs goes out in that same frame
      f_clr = 1; f_n = 0; run_frame();
      f_clr = 0; f_byp = 1; f_b = '{16'h3333, 16'h3333}; f_n = 1; run_frame();
      f_byp = 0;
      chk("bypass_data", {16'd0, dec.l}, 32'h3333);
      chk("bypass_no_ur", {31'd0, underrun}, 0);

      // ramp down to silence
      f_on = 0;
      for (int i = 0; i < 64; i++) run_frame();
      chk("ramp_down_gain", {23'd0, gain}, 0);
      n0 = nfr;
      run_frame();
      f_n = 0; run_frame();
      chk("silent_frames_run", 32'(nfr - n0), 2);
      chk("silent_data", {dec.l, dec.r}, 0);

      // async reset mid-frame with gain and underrun live
      f_on = 1; f_rst200 = 1; run_frame();
      f_rst200 = 0;
      phase = 9'd0;
      repeat (2) tick();
      model_reset();
      rst = 0;
      f_lr_chk = 1; f_n = 1; f_s1 = fill; run_frame();
      f_lr_chk = 0; run_frame();
      chk("sb_drain", 32'(sbq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
